// File: rtl/mips_pkg.sv
// ============================================================================
// mips_pkg : store opcodes, store-queue entry type and drain FSM states
// Rev 1.0  : initial release
// ============================================================================
`default_nettype none

package mips_pkg;

  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SWL = 6'b101010;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SWR = 6'b101110;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } store_entry_t;

  typedef enum logic [0:0] {
    DRAIN_IDLE  = 1'b0,
    DRAIN_WRITE = 1'b1
  } drain_state_t;

endpackage

`default_nettype wire

// File: rtl/store_unit_if.sv
// ============================================================================
// store_unit_if : execute-stage store request and data-memory write port
// Rev 1.0       : initial release
// ============================================================================
`default_nettype none

interface store_unit_if;
  logic [31:0] instruction;
  logic [31:0] mem_address;
  logic [31:0] reg_t;
  logic        st_valid;
  logic        st_ready;
  logic        addr_error;
  logic        busy;
  logic [31:0] dmem_address;
  logic        dmem_write;
  logic [3:0]  dmem_byteenable;
  logic [31:0] dmem_writedata;
  logic        dmem_waitrequest;

  // Environment side: execute stage plus data memory.
  modport master (
    output instruction, mem_address, reg_t, st_valid, dmem_waitrequest,
    input  st_ready, addr_error, busy,
    input  dmem_address, dmem_write, dmem_byteenable, dmem_writedata
  );

  modport slave (
    input  instruction, mem_address, reg_t, st_valid, dmem_waitrequest,
    output st_ready, addr_error, busy,
    output dmem_address, dmem_write, dmem_byteenable, dmem_writedata
  );
endinterface

`default_nettype wire

// File: rtl/store_fifo.sv
// ============================================================================
// store_fifo : in-order queue of store entries, head visible combinationally
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module store_fifo
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  store_entry_t din_i,
  input  logic         pop_i,
  output store_entry_t head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         full_next_o,
  output logic         empty_next_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  store_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  assign full_next_o  = (count_d == FULL_CNT);
  assign empty_next_o = (count_d == '0);

  // Pointers are exactly log2(DEPTH) bits, so increments wrap on their own.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      count_q <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/store_unit.sv
// ============================================================================
// store_unit : big-endian store lane/mask generation, store queue and
//              valid/waitrequest drain to data memory
// Rev 1.0    : initial release
// ============================================================================
`default_nettype none

module store_unit
  import mips_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic         clk,
  input logic         reset_n,
  store_unit_if.slave bus
);

  logic [5:0]   opcode_w;
  logic [1:0]   k_w;
  logic [3:0]   be_w;
  logic [31:0]  data_w;
  logic         legal_w;
  logic         misalign_w;
  logic         accept_w;
  logic         push_w;
  logic         pop_w;
  logic         dmem_write_w;
  store_entry_t entry_w;
  store_entry_t head_w;
  logic         fifo_full_w;
  logic         fifo_empty_w;
  logic         full_next_w;
  logic         empty_next_w;
  logic         w_unused_instr;

  drain_state_t state_q;
  logic         st_ready_q;
  logic         busy_q;
  logic         addr_error_q;

  assign opcode_w       = bus.instruction[31:26];
  assign k_w            = bus.mem_address[1:0];
  assign w_unused_instr = ^bus.instruction[25:0];

  // Byte offset k lands on lane 3-k; swl/swr keep the register's
  // high/low bytes respectively and zero the lanes they do not write.
  always_comb begin
    be_w       = 4'b0000;
    data_w     = 32'h0;
    legal_w    = 1'b0;
    misalign_w = 1'b0;
    case (opcode_w)
      OP_SB: begin
        legal_w = 1'b1;
        be_w    = 4'b1000 >> k_w;
        data_w  = {4{bus.reg_t[7:0]}};
      end
      OP_SH: begin
        if (k_w[0]) begin
          misalign_w = 1'b1;
        end else begin
          legal_w = 1'b1;
          be_w    = k_w[1] ? 4'b0011 : 4'b1100;
          data_w  = {2{bus.reg_t[15:0]}};
        end
      end
      OP_SW: begin
        if (k_w != 2'd0) begin
          misalign_w = 1'b1;
        end else begin
          legal_w = 1'b1;
          be_w    = 4'b1111;
          data_w  = bus.reg_t;
        end
      end
      OP_SWL: begin
        legal_w = 1'b1;
        be_w    = 4'b1111 >> k_w;
        data_w  = bus.reg_t >> {k_w, 3'b000};
      end
      OP_SWR: begin
        legal_w = 1'b1;
        be_w    = 4'b1111 << (2'd3 - k_w);
        data_w  = bus.reg_t << {(2'd3 - k_w), 3'b000};
      end
      default: begin
        legal_w    = 1'b0;
        misalign_w = 1'b0;
      end
    endcase
  end

  assign entry_w.addr = {bus.mem_address[31:2], 2'b00};
  assign entry_w.be   = be_w;
  assign entry_w.data = data_w;

  assign accept_w     = bus.st_valid && st_ready_q;
  assign push_w       = accept_w && legal_w && !fifo_full_w;
  assign dmem_write_w = (state_q == DRAIN_WRITE);
  assign pop_w        = dmem_write_w && !bus.dmem_waitrequest && !fifo_empty_w;

  store_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push_w),
    .din_i        (entry_w),
    .pop_i        (pop_w),
    .head_o       (head_w),
    .full_o       (fifo_full_w),
    .empty_o      (fifo_empty_w),
    .full_next_o  (full_next_w),
    .empty_next_o (empty_next_w)
  );

  // st_ready tracks the post-edge occupancy, so a pop out of a full queue
  // only reopens the input on the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= DRAIN_IDLE;
      st_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
      addr_error_q <= 1'b0;
    end else begin
      st_ready_q   <= !full_next_w;
      busy_q       <= !empty_next_w;
      addr_error_q <= accept_w && misalign_w;
      case (state_q)
        DRAIN_IDLE: begin
          if (push_w) begin
            state_q <= DRAIN_WRITE;
          end
        end
        DRAIN_WRITE: begin
          if (empty_next_w) begin
            state_q <= DRAIN_IDLE;
          end
        end
        default: state_q <= DRAIN_IDLE;
      endcase
    end
  end

  assign bus.st_ready        = st_ready_q;
  assign bus.busy            = busy_q;
  assign bus.addr_error      = addr_error_q;
  assign bus.dmem_write      = dmem_write_w;
  assign bus.dmem_address    = dmem_write_w ? head_w.addr : 32'h0;
  assign bus.dmem_byteenable = dmem_write_w ? head_w.be   : 4'b0000;
  assign bus.dmem_writedata  = dmem_write_w ? head_w.data : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_store_unit.sv
// ============================================================================
// tb_store_unit : vector table, corner sequences and randomized run against a
//                 byte-level store model for store_unit
// Rev 1.0       : initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_store_unit;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 2;
  localparam logic [5:0]  OP_LW = 6'b100011;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  store_unit_if bus();

  store_unit #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic valid, input logic [5:0] op,
                       input logic [31:0] addr, input logic [31:0] regt);
    bus.st_valid    = valid;
    bus.instruction = {op, 26'($urandom)};
    bus.mem_address = addr;
    bus.reg_t       = regt;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Byte-level model: memory byte offsets written and the byte each receives.
  function automatic void ref_store(input logic [5:0] op, input logic [31:0] addr,
                                    input logic [31:0] regt, output bit push,
                                    output bit err, output store_entry_t e);
    int k = int'(addr[1:0]);
    logic [7:0] rb [4];
    logic [7:0] mb [4];
    bit         we [4];
    push = 1'b0;
    err  = 1'b0;
    e    = '0;
    for (int j = 0; j < 4; j++) begin
      rb[j] = regt[31-8*j -: 8];
      mb[j] = 8'h00;
      we[j] = 1'b0;
    end
    case (op)
      OP_SB: begin
        for (int j = 0; j < 4; j++) mb[j] = rb[3];
        we[k] = 1'b1;
        push  = 1'b1;
      end
      OP_SH: begin
        if (k % 2 != 0) err = 1'b1;
        else begin
          for (int j = 0; j < 4; j++) mb[j] = rb[2 + j % 2];
          we[k] = 1'b1; we[k+1] = 1'b1;
          push  = 1'b1;
        end
      end
      OP_SW: begin
        if (k != 0) err = 1'b1;
        else begin
          for (int j = 0; j < 4; j++) begin mb[j] = rb[j]; we[j] = 1'b1; end
          push = 1'b1;
        end
      end
      OP_SWL: begin
        for (int j = 0; j <= 3 - k; j++) begin mb[k+j] = rb[j]; we[k+j] = 1'b1; end
        push = 1'b1;
      end
      OP_SWR: begin
        for (int j = 0; j <= k; j++) begin mb[j] = rb[3-k+j]; we[j] = 1'b1; end
        push = 1'b1;
      end
      default: ;
    endcase
    if (push) begin
      e.addr = addr & 32'hFFFF_FFFC;
      for (int i = 0; i < 4; i++) begin
        e.be[3-i]           = we[i];
        e.data[31-8*i -: 8] = mb[i];
      end
    end
  endfunction

  typedef struct {
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] regt;
    bit          wr;
    bit          err;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] edata;
  } vec_t;

  vec_t vt [18];

  store_entry_t q [$];
  store_entry_t e;
  bit           m_push, m_err, exp_err, accepted;
  logic [5:0]   op;
  logic [31:0]  ex_a, ex_b, ex_c;

  initial begin
    vt[0]  = '{OP_SB,  32'h0000_0101, 32'h1122_3344, 1, 0, 32'h100, 4'b0100, 32'h4444_4444};
    vt[1]  = '{OP_SB,  32'h0000_0003, 32'h1122_3355, 1, 0, 32'h000, 4'b0001, 32'h5555_5555};
    vt[2]  = '{OP_SH,  32'h0000_0102, 32'h1122_3344, 1, 0, 32'h100, 4'b0011, 32'h3344_3344};
    vt[3]  = '{OP_SH,  32'h0000_0100, 32'hFFFF_BEEF, 1, 0, 32'h100, 4'b1100, 32'hBEEF_BEEF};
    vt[4]  = '{OP_SH,  32'h0000_0101, 32'h1122_3344, 0, 1, 32'h0,   4'b0000, 32'h0};
    vt[5]  = '{OP_SW,  32'h8000_0200, 32'hCAFE_F00D, 1, 0, 32'h8000_0200, 4'b1111, 32'hCAFE_F00D};
    vt[6]  = '{OP_SW,  32'h0000_0103, 32'h1234_5678, 0, 1, 32'h0,   4'b0000, 32'h0};
    vt[7]  = '{OP_SWL, 32'h0000_0200, 32'hAABB_CCDD, 1, 0, 32'h200, 4'b1111, 32'hAABB_CCDD};
    vt[8]  = '{OP_SWL, 32'h0000_0201, 32'hAABB_CCDD, 1, 0, 32'h200, 4'b0111, 32'h00AA_BBCC};
    vt[9]  = '{OP_SWL, 32'h0000_0202, 32'hAABB_CCDD, 1, 0, 32'h200, 4'b0011, 32'h0000_AABB};
    vt[10] = '{OP_SWL, 32'h0000_0203, 32'hAABB_CCDD, 1, 0, 32'h200, 4'b0001, 32'h0000_00AA};
    vt[11] = '{OP_SWR, 32'h0000_0200, 32'hAABB_CCDD, 1, 0, 32'h200, 4'b1000, 32'hDD00_0000};
    vt[12] = '{OP_SWR, 32'h0000_0201, 32'hAABB_CCDD, 1, 0, 32'h200, 4'b1100, 32'hCCDD_0000};
    vt[13] = '{OP_SWR, 32'h0000_0202, 32'hAABB_CCDD, 1, 0, 32'h200, 4'b1110, 32'hBBCC_DD00};
    vt[14] = '{OP_SWR, 32'h0000_0203, 32'hAABB_CCDD, 1, 0, 32'h200, 4'b1111, 32'hAABB_CCDD};
    vt[15] = '{OP_LW,  32'h0000_0100, 32'h1111_1111, 0, 0, 32'h0,   4'b0000, 32'h0};
    vt[16] = '{6'h00,  32'h0000_0100, 32'h2222_2222, 0, 0, 32'h0,   4'b0000, 32'h0};
    vt[17] = '{OP_SW,  32'h0000_0102, 32'h3333_3333, 0, 1, 32'h0,   4'b0000, 32'h0};

    drive(1'b0, 6'h00, 32'h0, 32'h0);
    bus.dmem_waitrequest = 1'b0;
    do_reset();

    @(negedge clk);
    chk("reset st_ready",   32'(bus.st_ready), 32'h1);
    chk("reset addr_error", 32'(bus.addr_error), 32'h0);
    chk("reset busy",       32'(bus.busy), 32'h0);
    chk("reset dmem_write", 32'(bus.dmem_write), 32'h0);
    chk("reset dmem_addr",  bus.dmem_address, 32'h0);
    chk("reset dmem_be",    32'(bus.dmem_byteenable), 32'h0);
    chk("reset dmem_data",  bus.dmem_writedata, 32'h0);

    for (int i = 0; i < 18; i++) begin
      drive(1'b1, vt[i].op, vt[i].addr, vt[i].regt);
      @(negedge clk);
      bus.st_valid = 1'b0;
      chk($sformatf("vec%0d dmem_write", i), 32'(bus.dmem_write), 32'(vt[i].wr));
      chk($sformatf("vec%0d addr_error", i), 32'(bus.addr_error), 32'(vt[i].err));
      chk($sformatf("vec%0d busy", i),       32'(bus.busy), 32'(vt[i].wr));
      if (vt[i].wr) begin
        chk($sformatf("vec%0d dmem_addr", i), bus.dmem_address, vt[i].eaddr);
        chk($sformatf("vec%0d dmem_be", i),   32'(bus.dmem_byteenable), 32'(vt[i].ebe));
        chk($sformatf("vec%0d dmem_data", i), bus.dmem_writedata, vt[i].edata);
      end
      @(negedge clk);
      chk($sformatf("vec%0d drained", i),   32'(bus.dmem_write), 32'h0);
      chk($sformatf("vec%0d err pulse", i), 32'(bus.addr_error), 32'h0);
      chk($sformatf("vec%0d busy low", i),  32'(bus.busy), 32'h0);
    end

    // swl then swr back to back: issued in order.
    drive(1'b1, OP_SWL, 32'h202, 32'hAABB_CCDD);
    @(negedge clk);
    drive(1'b1, OP_SWR, 32'h201, 32'hAABB_CCDD);
    chk("pair first data", bus.dmem_writedata, 32'h0000_AABB);
    chk("pair first be",   32'(bus.dmem_byteenable), 32'h3);
    @(negedge clk);
    bus.st_valid = 1'b0;
    chk("pair second data", bus.dmem_writedata, 32'hCCDD_0000);
    chk("pair second be",   32'(bus.dmem_byteenable), 32'hC);
    @(negedge clk);
    chk("pair drained", 32'(bus.dmem_write), 32'h0);

    // Full queue under waitrequest, then release.
    ex_a = 32'hA000_0001; ex_b = 32'hB000_0002; ex_c = 32'hC000_0003;
    bus.dmem_waitrequest = 1'b1;
    drive(1'b1, OP_SW, 32'h400, ex_a);
    @(negedge clk);
    chk("full ready after 1", 32'(bus.st_ready), 32'h1);
    chk("full head A",        bus.dmem_writedata, ex_a);
    drive(1'b1, OP_SW, 32'h404, ex_b);
    @(negedge clk);
    chk("full ready after 2", 32'(bus.st_ready), 32'h0);
    chk("full hold A data",   bus.dmem_writedata, ex_a);
    drive(1'b1, OP_SW, 32'h408, ex_c);
    @(negedge clk);
    chk("full still blocked", 32'(bus.st_ready), 32'h0);
    chk("full hold A addr",   bus.dmem_address, 32'h400);
    chk("full hold A write",  32'(bus.dmem_write), 32'h1);
    bus.dmem_waitrequest = 1'b0;
    @(negedge clk);
    chk("full pop-cycle ready", 32'(bus.st_ready), 32'h1);
    chk("full head B",          bus.dmem_writedata, ex_b);
    chk("full head B addr",     bus.dmem_address, 32'h404);
    @(negedge clk);
    bus.st_valid = 1'b0;
    chk("full head C",      bus.dmem_writedata, ex_c);
    chk("full head C addr", bus.dmem_address, 32'h408);
    @(negedge clk);
    chk("full drained", 32'(bus.dmem_write), 32'h0);
    chk("full busy low", 32'(bus.busy), 32'h0);

    // Reset in the middle of a stall discards queued stores.
    bus.dmem_waitrequest = 1'b1;
    drive(1'b1, OP_SW, 32'h500, 32'h5555_0001);
    @(negedge clk);
    drive(1'b1, OP_SW, 32'h504, 32'h5555_0002);
    @(negedge clk);
    bus.st_valid = 1'b0;
    chk("rst pre busy", 32'(bus.busy), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst dmem_write", 32'(bus.dmem_write), 32'h0);
    chk("rst dmem_addr",  bus.dmem_address, 32'h0);
    chk("rst dmem_data",  bus.dmem_writedata, 32'h0);
    chk("rst dmem_be",    32'(bus.dmem_byteenable), 32'h0);
    chk("rst busy",       32'(bus.busy), 32'h0);
    chk("rst st_ready",   32'(bus.st_ready), 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
    bus.dmem_waitrequest = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post-rst no write", 32'(bus.dmem_write), 32'h0);
      chk("post-rst busy",     32'(bus.busy), 32'h0);
    end

    // Randomized run against the byte-level model.
    q.delete();
    exp_err = 1'b0;
    for (int cyc = 0; cyc < 800; cyc++) begin
      @(negedge clk);
      chk("rnd st_ready",   32'(bus.st_ready), 32'(q.size() < int'(DEPTH)));
      chk("rnd busy",       32'(bus.busy), 32'(q.size() != 0));
      chk("rnd dmem_write", 32'(bus.dmem_write), 32'(q.size() != 0));
      chk("rnd addr_error", 32'(bus.addr_error), 32'(exp_err));
      if (q.size() != 0) begin
        chk("rnd dmem_addr", bus.dmem_address, q[0].addr);
        chk("rnd dmem_be",   32'(bus.dmem_byteenable), 32'(q[0].be));
        chk("rnd dmem_data", bus.dmem_writedata, q[0].data);
      end
      case ($urandom_range(0, 6))
        0: op = OP_SB;
        1: op = OP_SH;
        2: op = OP_SW;
        3: op = OP_SWL;
        4: op = OP_SWR;
        5: op = OP_LW;
        default: op = 6'($urandom);
      endcase
      drive($urandom_range(0, 99) < 70, op, $urandom, $urandom);
      bus.dmem_waitrequest = ($urandom_range(0, 99) < 40);
      accepted = bus.st_valid && (q.size() < int'(DEPTH));
      ref_store(op, bus.mem_address, bus.reg_t, m_push, m_err, e);
      exp_err = accepted && m_err;
      if (q.size() != 0 && !bus.dmem_waitrequest) void'(q.pop_front());
      if (accepted && m_push) q.push_back(e);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/store_unit.md
# store_unit

Data-memory write path of the Harvard datapath: accepts store requests (sb, sh, sw, swl, swr) from the execute stage and converts each into a word-aligned address, a byte-enable mask and lane-aligned write data. Stores are buffered in a small in-order queue and drained to data memory through a valid/waitrequest handshake. The block sits between the execute stage and the data-memory port. It is the write-side counterpart of the load-merge logic: the same big-endian byte numbering and the same lwl/lwr-style partial-word rules, applied in the store direction.

## Interface
- DEPTH, 2, store-queue entries; power of two, ≥2
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous, active-low reset
- instruction  input  32  current instruction; opcode = [31:26]
- mem_address  input  32  effective byte address
- reg_t  input  32  store source register value
- st_valid  input  1  store request valid
- st_ready  output  1  queue can accept; registered, equals !full
- addr_error  output  1  one-cycle pulse: misaligned sh/sw was rejected
- busy  output  1  queue non-empty; load logic must stall while high
- dmem_address  output  32  word address of head entry, [1:0]=0
- dmem_write  output  1  head entry valid
- dmem_byteenable  output  4  bit 3 = bits [31:24] = byte offset 0
- dmem_writedata  output  32  lane-aligned data
- dmem_waitrequest  input  1  memory stalls the current write

## Operation
- Big-endian: byte offset k (k = mem_address[1:0]) maps to lane 3-k, i.e. bits [31-8k -: 8].
- sb (101000): be = one-hot lane 3-k; data = {4{reg_t[7:0]}}.
- sh (101001): k=0 → be 1100; k=2 → be 0011; data = {2{reg_t[15:0]}}. k=1 or 3 → misaligned.
- sw (101011): k=0 → be 1111, data = reg_t; any other k → misaligned.
- swl (101010): k=0/1/2/3 → be 1111/0111/0011/0001; data = reg_t >> 8k.
- swr (101110): k=0/1/2/3 → be 1000/1100/1110/1111; data = reg_t << 8(3-k).
- Any other opcode: the handshake completes and the request is dropped. No enqueue and no error.
- Accept occurs when st_valid && st_ready.
  - Legal store: push {mem_address[31:2],2'b00, be, data}.
  - Misaligned store: no push; addr_error = 1 in the following cycle only.
- Drain FSM:
  - IDLE: queue empty, dmem_write = 0.
  - WRITE: head presented with dmem_write = 1.
  - Pop when dmem_write && !dmem_waitrequest.
  - WRITE → IDLE when the last entry pops with no push in the same cycle.
- While dmem_waitrequest is high, dmem_address, dmem_byteenable and dmem_writedata hold stable.
- Ordering is strictly FIFO. No merging or coalescing.

## Timing
- Reset (async assert, sync deassert expected): queue empty, FSM IDLE. st_ready=1. addr_error, busy, dmem_write, dmem_byteenable, dmem_address and dmem_writedata are all 0.
- Reset asserted mid-operation discards all pending stores immediately.
- Latency from accept to dmem_write high is 1 cycle, when the queue is empty.
- Throughput is one store per cycle when dmem_waitrequest stays low.
- Full: st_ready=0, even if a pop occurs in the same cycle. st_ready rises the cycle after the pop.
- Push and pop in the same cycle (not full, not empty): count unchanged, both take effect.
- Empty with a push: the pushed entry is visible the next cycle, never in the same cycle.
- Pointers are log2(DEPTH) bits wide and wrap naturally. The count is log2(DEPTH)+1 bits.
- busy goes high the cycle after the first push and low the cycle after the final pop.

## Structure
- Shared package mips_pkg holds:
  - opcode localparams OP_SB, OP_SH, OP_SW, OP_SWL, OP_SWR
  - store_entry_t struct {addr[31:0], be[3:0], data[31:0]}
- Sub-module store_fifo: parameterised DEPTH queue of store_entry_t with push/pop/full/empty.
- Lane/mask generation stays combinational in store_unit. The FSM and addr_error register also live in store_unit.

## Test plan
- sb of reg_t=0x11223344 to addr 0x101, waitrequest=0 → one cycle later: dmem_address=0x100, be=0100, data=0x44444444. The entry pops that cycle.
- swl reg_t=0xAABBCCDD @0x202 → be=0011, data=0x0000AABB. swr same value @0x201 → be=1100, data=0xCCDD0000. Both are issued in that order.
- sw @0x103 → addr_error pulses exactly one cycle, no dmem_write, busy stays 0. sh @0x102 is accepted with be=0011.
- waitrequest held high, DEPTH=2, three back-to-back sw:
  - st_ready drops after the second accept.
  - Outputs stay stable at the first entry.
  - Release waitrequest → writes complete in order, and st_ready returns the cycle after the first pop.
- Two entries queued, reset_n pulsed low mid-stall → all outputs 0 immediately. After release, no stale write appears.
- st_valid with opcode 100011 (lw) → accepted, no write, no error, busy remains 0.
